// File: rtl/pkg_en.sv
// Shared ElectronNest token types and bus widths.
package pkg_en;
  parameter int unsigned WIDTH_DATA   = 32;
  parameter int unsigned WIDTH_EXADDR = 16;

  typedef struct packed {
    logic                  v;
    logic                  a;
    logic                  r;
    logic                  c;
    logic [WIDTH_DATA-1:0] d;
  } FTk_t;

  typedef struct packed {
    logic n;
  } BTk_t;
endpackage

// File: rtl/en_ext_mem_ctrl_if.sv
// Load/store/SRAM bundle between the ElectronNest top and the external memory controller.
interface en_ext_mem_ctrl_if;
  logic                                I_Boot;
  logic                                I_Ld_Req;
  logic [pkg_en::WIDTH_EXADDR-1:0]     I_Ld_Addr;
  pkg_en::FTk_t                        O_Ld_FTk;
  pkg_en::BTk_t                        I_Ld_BTk;
  logic                                O_Ld_Stall;
  logic                                I_St_Req;
  logic [pkg_en::WIDTH_EXADDR-1:0]     I_St_Addr;
  pkg_en::FTk_t                        I_St_FTk;
  pkg_en::BTk_t                        O_St_BTk;
  logic                                O_Mem_En;
  logic                                O_Mem_We;
  logic [pkg_en::WIDTH_EXADDR-1:0]     O_Mem_Addr;
  logic [pkg_en::WIDTH_DATA-1:0]       O_Mem_WData;
  logic [pkg_en::WIDTH_DATA-1:0]       I_Mem_RData;
  logic                                O_Busy;

  modport master (
    output I_Boot, I_Ld_Req, I_Ld_Addr, I_Ld_BTk, I_St_Req, I_St_Addr, I_St_FTk, I_Mem_RData,
    input  O_Ld_FTk, O_Ld_Stall, O_St_BTk, O_Mem_En, O_Mem_We, O_Mem_Addr, O_Mem_WData, O_Busy
  );

  modport slave (
    input  I_Boot, I_Ld_Req, I_Ld_Addr, I_Ld_BTk, I_St_Req, I_St_Addr, I_St_FTk, I_Mem_RData,
    output O_Ld_FTk, O_Ld_Stall, O_St_BTk, O_Mem_En, O_Mem_We, O_Mem_Addr, O_Mem_WData, O_Busy
  );
endinterface

// File: rtl/en_ext_mem_ctrl.sv
// Single-port SRAM sequencer: boot token stream, then round-robin load/store arbitration
// with a one-entry replay register for load-token backpressure.
module en_ext_mem_ctrl #(
  parameter int unsigned BOOT_PAD   = 3,
  parameter int unsigned BOOT_WORDS = 5
) (
  input logic              clock,
  input logic              reset,
  en_ext_mem_ctrl_if.slave bus
);
  import pkg_en::*;

  localparam int unsigned BootTotal = BOOT_PAD + BOOT_WORDS;
  localparam int unsigned CntW      = $clog2(BootTotal + 1);
  localparam logic [CntW-1:0] PadCnt   = CntW'(BOOT_PAD);
  localparam logic [CntW-1:0] TotalCnt = CntW'(BootTotal);

  typedef enum logic [0:0] {StRun, StBoot} state_e;

  state_e          state_q;
  logic            rr_q;  // 0: load wins a contended cycle
  logic [CntW-1:0] issued_q;
  logic [CntW-1:0] consumed_q;
  logic            pend_v_q;
  logic            pend_a_q;
  logic            pend_mem_q;
  logic            hold_v_q;
  FTk_t            hold_tok_q;

  FTk_t            ld_tok;
  logic            out_blocked;
  logic            tok_taken;
  logic            ld_want;
  logic            st_want;
  logic            ld_gnt;
  logic            st_gnt;
  logic            boot_go;
  logic            boot_issue;
  logic [CntW-1:0] boot_k;
  logic            boot_mem;
  logic            unused_st_bits;

  assign unused_st_bits = ^{bus.I_St_FTk.a, bus.I_St_FTk.r, bus.I_St_FTk.c};

  // The replayed token wins over a fresh one; a fresh token's data comes straight off the SRAM.
  always_comb begin
    ld_tok = '0;
    if (hold_v_q) begin
      ld_tok = hold_tok_q;
    end else if (pend_v_q) begin
      ld_tok.v = 1'b1;
      ld_tok.a = pend_a_q;
      ld_tok.d = pend_mem_q ? bus.I_Mem_RData : '0;
    end
  end

  assign out_blocked = ld_tok.v & bus.I_Ld_BTk.n;
  assign tok_taken   = ld_tok.v & ~bus.I_Ld_BTk.n;
  assign ld_want     = bus.I_Ld_Req & ~hold_v_q & ~out_blocked;
  assign st_want     = bus.I_St_Req & bus.I_St_FTk.v;
  assign boot_go     = (state_q == StRun) & bus.I_Boot & ~hold_v_q & ~out_blocked;

  // Token 0 is issued on the accept cycle so the stream starts the cycle BOOT is entered.
  assign boot_issue = boot_go |
                      ((state_q == StBoot) & (issued_q != TotalCnt) & ~out_blocked);
  assign boot_k     = boot_go ? '0 : issued_q;
  assign boot_mem   = boot_k >= PadCnt;

  always_comb begin
    ld_gnt = 1'b0;
    st_gnt = 1'b0;
    if (state_q == StRun && !boot_go) begin
      if (ld_want && st_want) begin
        ld_gnt = ~rr_q;
        st_gnt = rr_q;
      end else begin
        ld_gnt = ld_want;
        st_gnt = st_want;
      end
    end
  end

  always_comb begin
    bus.O_Mem_En    = 1'b0;
    bus.O_Mem_We    = 1'b0;
    bus.O_Mem_Addr  = '0;
    bus.O_Mem_WData = '0;
    if (reset) begin
      if (boot_issue && boot_mem) begin
        bus.O_Mem_En   = 1'b1;
        bus.O_Mem_Addr = WIDTH_EXADDR'(boot_k - PadCnt);
      end else if (ld_gnt) begin
        bus.O_Mem_En   = 1'b1;
        bus.O_Mem_Addr = bus.I_Ld_Addr;
      end else if (st_gnt) begin
        bus.O_Mem_En    = 1'b1;
        bus.O_Mem_We    = 1'b1;
        bus.O_Mem_Addr  = bus.I_St_Addr;
        bus.O_Mem_WData = bus.I_St_FTk.d;
      end
    end
  end

  assign bus.O_Ld_FTk   = ld_tok;
  assign bus.O_Ld_Stall = reset & ((state_q == StBoot) | (bus.I_Ld_Req & ~ld_gnt));
  assign bus.O_St_BTk.n = reset & ((state_q == StBoot) | (st_want & ~st_gnt));
  assign bus.O_Busy     = (state_q == StBoot);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StRun;
      rr_q       <= 1'b0;
      issued_q   <= '0;
      consumed_q <= '0;
      pend_v_q   <= 1'b0;
      pend_a_q   <= 1'b0;
      pend_mem_q <= 1'b0;
      hold_v_q   <= 1'b0;
      hold_tok_q <= '0;
    end else begin
      hold_v_q <= out_blocked;
      if (out_blocked) begin
        hold_tok_q <= ld_tok;
      end
      pend_v_q   <= boot_issue | ld_gnt;
      pend_a_q   <= boot_issue & (boot_k == '0);
      pend_mem_q <= boot_issue ? boot_mem : 1'b1;
      if (boot_issue) begin
        issued_q <= boot_k + 1'b1;
      end
      if ((ld_gnt & st_want) | (st_gnt & ld_want)) begin
        rr_q <= ~rr_q;
      end
      if (boot_go) begin
        state_q    <= StBoot;
        consumed_q <= '0;
      end else if (state_q == StBoot && tok_taken) begin
        if (consumed_q == TotalCnt - 1'b1) begin
          state_q <= StRun;
        end
        consumed_q <= consumed_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_en_ext_mem_ctrl.sv
// Directed bench for en_ext_mem_ctrl with a cycle-level reference model and literal spot checks.
module tb_en_ext_mem_ctrl;
  import pkg_en::*;

  localparam int Pad   = 3;
  localparam int Words = 5;
  localparam int Total = Pad + Words;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  en_ext_mem_ctrl_if bus ();

  en_ext_mem_ctrl #(
    .BOOT_PAD   (Pad),
    .BOOT_WORDS (Words)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural SRAM seen by the DUT, and the bench's own view of memory contents.
  logic [31:0] sram [64];
  logic [31:0] mm   [64];

  always @(posedge clock) begin
    if (bus.O_Mem_En) begin
      if (bus.O_Mem_We) sram[bus.O_Mem_Addr[5:0]] <= bus.O_Mem_WData;
      else              bus.I_Mem_RData <= sram[bus.O_Mem_Addr[5:0]];
    end
  end

  // Reference model: token due this cycle, held token, boot progress, arbitration priority.
  logic        m_boot, m_ld_first, m_hold_v, m_hold_a, m_resp_v, m_resp_a;
  logic [31:0] m_hold_d, m_resp_d;
  int          m_issued, m_left;
  logic        e_v, e_a, e_stall, e_stn, e_en, e_we, blocked, lw, sw, take_ld, take_st;
  logic        issue, start_boot;
  logic [31:0] e_d, e_wd;
  logic [15:0] e_addr;
  int          k;

  always @(negedge clock) begin
    if (!reset) begin
      m_boot = 0; m_issued = 0; m_left = 0; m_ld_first = 1; m_hold_v = 0; m_resp_v = 0;
      check("rst_ftk", bus.O_Ld_FTk, '0);
      check("rst_stall", bus.O_Ld_Stall, 0);
      check("rst_st_n", bus.O_St_BTk.n, 0);
      check("rst_mem", {bus.O_Mem_En, bus.O_Mem_We, bus.O_Mem_Addr, bus.O_Mem_WData}, '0);
      check("rst_busy", bus.O_Busy, 0);
    end else begin
      e_v = 0; e_a = 0; e_d = '0;
      if (m_hold_v) begin
        e_v = 1; e_a = m_hold_a; e_d = m_hold_d;
      end else if (m_resp_v) begin
        e_v = 1; e_a = m_resp_a; e_d = m_resp_d;
      end
      blocked = e_v & bus.I_Ld_BTk.n;
      sw = bus.I_St_Req & bus.I_St_FTk.v;
      e_en = 0; e_we = 0; e_addr = '0; e_wd = '0;
      issue = 0; k = 0; take_ld = 0; take_st = 0; start_boot = 0;
      if (m_boot) begin
        e_stall = 1; e_stn = 1;
        if (m_issued < Total && !blocked) begin issue = 1; k = m_issued; end
      end else if (bus.I_Boot && !m_hold_v && !blocked) begin
        e_stall = bus.I_Ld_Req; e_stn = sw; issue = 1; k = 0; start_boot = 1;
      end else begin
        lw = bus.I_Ld_Req & !m_hold_v & !blocked;
        if (lw && sw) begin
          if (m_ld_first) take_ld = 1; else take_st = 1;
          m_ld_first = !m_ld_first;
        end else begin
          take_ld = lw; take_st = sw;
        end
        e_stall = bus.I_Ld_Req & !take_ld;
        e_stn   = sw & !take_st;
      end
      if (issue && k >= Pad) begin e_en = 1; e_addr = 16'(k - Pad); end
      if (take_ld) begin e_en = 1; e_addr = bus.I_Ld_Addr; end
      if (take_st) begin e_en = 1; e_we = 1; e_addr = bus.I_St_Addr; e_wd = bus.I_St_FTk.d; end

      check("m_busy", bus.O_Busy, m_boot);
      check("m_ld_v", bus.O_Ld_FTk.v, e_v);
      if (e_v) begin
        check("m_ld_a", bus.O_Ld_FTk.a, e_a);
        check("m_ld_rc", {bus.O_Ld_FTk.r, bus.O_Ld_FTk.c}, 2'b00);
        check("m_ld_d", bus.O_Ld_FTk.d, e_d);
      end
      check("m_ld_stall", bus.O_Ld_Stall, e_stall);
      check("m_st_n", bus.O_St_BTk.n, e_stn);
      check("m_mem_en", bus.O_Mem_En, e_en);
      if (e_en) begin
        check("m_mem_we", bus.O_Mem_We, e_we);
        check("m_mem_addr", bus.O_Mem_Addr, e_addr);
        if (e_we) check("m_mem_wdata", bus.O_Mem_WData, e_wd);
      end

      if (m_boot && e_v && !bus.I_Ld_BTk.n) begin
        m_left--;
        if (m_left == 0) m_boot = 0;
      end
      m_hold_v = blocked;
      if (blocked) begin m_hold_a = e_a; m_hold_d = e_d; end
      m_resp_v = issue | take_ld;
      if (issue) begin
        m_resp_a = (k == 0);
        m_resp_d = (k < Pad) ? 32'h0 : mm[k - Pad];
        m_issued = k + 1;
      end else if (take_ld) begin
        m_resp_a = 0;
        m_resp_d = mm[bus.I_Ld_Addr[5:0]];
      end
      if (start_boot) begin m_boot = 1; m_left = Total; end
      if (take_st) mm[bus.I_St_Addr[5:0]] = bus.I_St_FTk.d;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [31:0] boot_exp [Total] = '{32'h0, 32'h0, 32'h0, 32'hCAFE_00A0, 32'hCAFE_00A1,
                                    32'hCAFE_00A2, 32'hCAFE_00A3, 32'hCAFE_00A4};
  logic [31:0] got_d [16];
  logic        got_a [16];
  int          ntok, nbusy;

  // Pulses I_Boot for one cycle, then records consumed tokens and busy cycles.
  task automatic boot_run(input int ncyc);
    ntok = 0; nbusy = 0;
    bus.I_Boot = 1;
    @(negedge clock);
    tick();
    bus.I_Boot = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clock);
      if (bus.O_Busy) nbusy++;
      if (bus.O_Ld_FTk.v && !bus.I_Ld_BTk.n && ntok < 16) begin
        got_d[ntok] = bus.O_Ld_FTk.d;
        got_a[ntok] = bus.O_Ld_FTk.a;
        ntok++;
      end
      tick();
    end
  endtask

  task automatic check_boot(input string tag);
    check({tag, "_ntok"}, ntok, Total);
    for (int i = 0; i < Total; i++) begin
      check({tag, "_d"}, got_d[i], boot_exp[i]);
      check({tag, "_a"}, got_a[i], (i == 0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) begin sram[i] = '0; mm[i] = '0; end
    for (int i = 0; i < Words; i++) begin
      sram[i] = 32'hCAFE_00A0 + i; mm[i] = 32'hCAFE_00A0 + i;
    end
    sram[16] = 32'h1234; mm[16] = 32'h1234;
    sram[33] = 32'h55;   mm[33] = 32'h55;
    bus.I_Boot = 0; bus.I_Ld_Req = 0; bus.I_Ld_Addr = '0; bus.I_Ld_BTk = '0;
    bus.I_St_Req = 0; bus.I_St_Addr = '0; bus.I_St_FTk = '0;
    #1 reset = 0;
    @(negedge clock);
    check("reset_busy", bus.O_Busy, 0);
    check("reset_ftk_v", bus.O_Ld_FTk.v, 0);
    tick(); tick();
    reset = 1;
    tick();

    // T1: boot stream
    boot_run(10);
    check_boot("t1");
    check("t1_busy_cycles", nbusy, 8);

    // T2: single load
    bus.I_Ld_Req = 1; bus.I_Ld_Addr = 16'h10;
    @(negedge clock);
    check("t2_en", {bus.O_Mem_En, bus.O_Mem_We}, 2'b10);
    check("t2_addr", bus.O_Mem_Addr, 16'h10);
    check("t2_stall", bus.O_Ld_Stall, 0);
    tick();
    bus.I_Ld_Req = 0;
    @(negedge clock);
    check("t2_tok", {bus.O_Ld_FTk.v, bus.O_Ld_FTk.d}, {1'b1, 32'h1234});
    tick();

    // T3: store then load same address
    bus.I_St_Req = 1; bus.I_St_Addr = 16'h5; bus.I_St_FTk.v = 1; bus.I_St_FTk.d = 32'hBEEF;
    @(negedge clock);
    check("t3_we", {bus.O_Mem_En, bus.O_Mem_We}, 2'b11);
    check("t3_wdata", bus.O_Mem_WData, 32'hBEEF);
    tick();
    bus.I_St_Req = 0; bus.I_St_FTk = '0;
    bus.I_Ld_Req = 1; bus.I_Ld_Addr = 16'h5;
    @(negedge clock);
    tick();
    bus.I_Ld_Req = 0;
    @(negedge clock);
    check("t3_tok", {bus.O_Ld_FTk.v, bus.O_Ld_FTk.d}, {1'b1, 32'hBEEF});
    tick();

    // T4: contention right after reset
    reset = 0;
    tick();
    reset = 1;
    bus.I_Ld_Req = 1; bus.I_Ld_Addr = 16'h10;
    bus.I_St_Req = 1; bus.I_St_Addr = 16'h20; bus.I_St_FTk.v = 1; bus.I_St_FTk.d = 32'h77;
    @(negedge clock);
    check("t4_c0", {bus.O_Ld_Stall, bus.O_St_BTk.n, bus.O_Mem_We}, 3'b010);
    tick();
    @(negedge clock);
    check("t4_c1", {bus.O_Ld_Stall, bus.O_St_BTk.n, bus.O_Mem_We}, 3'b101);
    check("t4_c1_addr", bus.O_Mem_Addr, 16'h20);
    tick();
    bus.I_Ld_Req = 0; bus.I_St_Req = 0; bus.I_St_FTk = '0;
    @(negedge clock);
    tick();

    // T5: backpressure with a store to the held token's address mid-hold
    bus.I_Ld_Req = 1; bus.I_Ld_Addr = 16'h21;
    @(negedge clock);
    tick();
    bus.I_Ld_Addr = 16'h10;
    for (int c = 1; c <= 4; c++) begin
      bus.I_Ld_BTk.n = (c < 4);
      bus.I_St_Req = (c == 2); bus.I_St_Addr = 16'h21;
      bus.I_St_FTk.v = (c == 2); bus.I_St_FTk.d = 32'h99;
      @(negedge clock);
      check("t5_tok", {bus.O_Ld_FTk.v, bus.O_Ld_FTk.d}, {1'b1, 32'h55});
      check("t5_stall", bus.O_Ld_Stall, 1);
      if (c != 2) check("t5_no_en", bus.O_Mem_En, 0);
      else        check("t5_store", {bus.O_Mem_En, bus.O_Mem_We, bus.O_St_BTk.n}, 3'b110);
      tick();
    end
    bus.I_St_Req = 0; bus.I_St_FTk = '0;
    @(negedge clock);
    check("t5_regrant", {bus.O_Mem_En, bus.O_Mem_Addr}, {1'b1, 16'h10});
    tick();
    bus.I_Ld_Req = 0;
    @(negedge clock);
    check("t5_next_tok", bus.O_Ld_FTk.d, 32'h1234);
    tick();

    // T6: reset mid-boot, then reboot from pad word 0
    bus.I_Boot = 1;
    @(negedge clock);
    tick();
    bus.I_Boot = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      tick();
    end
    reset = 0;
    #1;
    check("t6_rst_out", {bus.O_Ld_FTk.v, bus.O_Busy, bus.O_Mem_En, bus.O_Ld_Stall}, 4'b0000);
    tick();
    reset = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check("t6_quiet", {bus.O_Ld_FTk.v, bus.O_Busy}, 2'b00);
      tick();
    end
    boot_run(10);
    check_boot("t6");
    check("t6_busy_cycles", nbusy, 8);

    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
